// File: rtl/capture_sequencer.sv
// Camera capture sequencer: synchronises raw camera timing, tracks lines/window and feeds RGB444 queues.
// Optional FRAME_STATS_EN adds saturating frame_cnt/drop_cnt outputs.
module capture_sequencer #(
    parameter int LINE_W      = 10,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              res_n,
    input  logic              vsync,
    input  logic              href,
    input  logic              pclk,
    input  logic [7:0]        din,
    input  logic              cfg_enable,
    input  logic [LINE_W-1:0] cfg_line_start,
    input  logic [LINE_W-1:0] cfg_line_end,
    input  logic              q_rful,
    input  logic              q_gful,
    input  logic              q_bful,
    output logic              shoot,
    output logic              odd,
    output logic [7:0]        dout,
    output logic [LINE_W-1:0] line_cnt,
    output logic              busy,
    output logic              frame_done,
`ifdef FRAME_STATS_EN
    output logic [15:0]       frame_cnt,
    output logic [15:0]       drop_cnt,
`endif
    output logic              overflow
);
    typedef enum logic [2:0] {IDLE, WAIT_VS, WAIT_LINE, CAPTURE, FRAME_END} state_t;
    state_t state, state_nx;

    logic [SYNC_STAGES-1:0]      vs_sr, hr_sr, pc_sr;
    logic [SYNC_STAGES-1:0][7:0] din_sr;
    logic vs_d, hr_d, pc_d;
    logic phase, drop_pix;

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            vs_sr  <= '0;
            hr_sr  <= '0;
            pc_sr  <= '0;
            din_sr <= '0;
            vs_d   <= 1'b0;
            hr_d   <= 1'b0;
            pc_d   <= 1'b0;
        end else begin
            vs_sr  <= {vs_sr[SYNC_STAGES-2:0], vsync};
            hr_sr  <= {hr_sr[SYNC_STAGES-2:0], href};
            pc_sr  <= {pc_sr[SYNC_STAGES-2:0], pclk};
            din_sr <= {din_sr[SYNC_STAGES-2:0], din};
            vs_d   <= vs_sr[SYNC_STAGES-1];
            hr_d   <= hr_sr[SYNC_STAGES-1];
            pc_d   <= pc_sr[SYNC_STAGES-1];
        end
    end

    logic vs_rise, vs_fall, hr_rise, hr_fall, strobe;
    logic [7:0] din_s;
    assign vs_rise = vs_sr[SYNC_STAGES-1] & ~vs_d;
    assign vs_fall = ~vs_sr[SYNC_STAGES-1] & vs_d;
    assign hr_rise = hr_sr[SYNC_STAGES-1] & ~hr_d;
    assign hr_fall = ~hr_sr[SYNC_STAGES-1] & hr_d;
    assign strobe  = pc_sr[SYNC_STAGES-1] & ~pc_d;
    assign din_s   = din_sr[SYNC_STAGES-1];

    // vsync rise inside a line closes the line exactly like an href fall
    logic line_end, cap_stb, in_win, q_full, drop_evt;
    assign line_end = hr_fall | vs_rise;
    assign cap_stb  = (state == CAPTURE) && strobe && !line_end;
    assign in_win   = (line_cnt >= cfg_line_start) && (line_cnt <= cfg_line_end);
    assign q_full   = q_rful | q_gful | q_bful;
    assign drop_evt = cap_stb && !phase && in_win && q_full;

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (cfg_enable) state_nx = WAIT_VS;
            WAIT_VS:   if (vs_fall) state_nx = WAIT_LINE;
            WAIT_LINE: if (vs_rise) state_nx = FRAME_END;
                       else if (hr_rise) state_nx = CAPTURE;
            CAPTURE:   if (vs_rise) state_nx = FRAME_END;
                       else if (hr_fall) state_nx = WAIT_LINE;
            FRAME_END: state_nx = cfg_enable ? WAIT_VS : IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    assign busy       = (state != IDLE);
    assign frame_done = (state == FRAME_END);

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            shoot    <= 1'b0;
            odd      <= 1'b1;
            dout     <= '0;
            line_cnt <= '0;
            overflow <= 1'b0;
            phase    <= 1'b0;
            drop_pix <= 1'b0;
        end else begin
            shoot <= 1'b0;
            if (state == IDLE && cfg_enable) overflow <= 1'b0;
            if (state == WAIT_VS && vs_fall) line_cnt <= '0;
            if (state == WAIT_LINE && hr_rise && !vs_rise) begin
                odd      <= 1'b1;
                phase    <= 1'b0;
                drop_pix <= 1'b0;
            end
            if (state == CAPTURE && line_end) begin
                if (line_cnt != '1) line_cnt <= line_cnt + LINE_W'(1);
                if (phase && in_win) overflow <= 1'b1;
            end
            if (cap_stb) begin
                phase <= ~phase;
                odd   <= ~phase;
                dout  <= din_s;
                // full flags only matter at the red byte; the g/b byte follows its fate
                if (!phase) begin
                    drop_pix <= drop_evt;
                    if (drop_evt) overflow <= 1'b1;
                    else if (in_win) shoot <= 1'b1;
                end else begin
                    drop_pix <= 1'b0;
                    if (in_win && !drop_pix) shoot <= 1'b1;
                end
            end
        end
    end

`ifdef FRAME_STATS_EN
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            frame_cnt <= '0;
            drop_cnt  <= '0;
        end else begin
            if (frame_done && frame_cnt != 16'hFFFF) frame_cnt <= frame_cnt + 16'd1;
            if (drop_evt && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_capture_sequencer.sv
// Scoreboard bench for capture_sequencer: stimulus pushes expected shots, a monitor pops on shoot.
module tb_capture_sequencer;
    localparam int LW = 10;

    logic          clk = 1'b0, res_n = 1'b0;
    logic          vsync = 1'b1, href = 1'b0, pclk = 1'b0;
    logic [7:0]    din = 8'h00;
    logic          cfg_enable = 1'b0;
    logic [LW-1:0] ls = '0, le = '0;
    logic          q_rful = 1'b0, q_gful = 1'b0, q_bful = 1'b0;
    logic          shoot, odd, busy, frame_done, overflow;
    logic [7:0]    dout;
    logic [LW-1:0] line_cnt;
`ifdef FRAME_STATS_EN
    logic [15:0]   frame_cnt, drop_cnt;
`endif

    capture_sequencer #(.LINE_W(LW), .SYNC_STAGES(2)) dut (
        .clk(clk), .res_n(res_n), .vsync(vsync), .href(href), .pclk(pclk), .din(din),
        .cfg_enable(cfg_enable), .cfg_line_start(ls), .cfg_line_end(le),
        .q_rful(q_rful), .q_gful(q_gful), .q_bful(q_bful),
        .shoot(shoot), .odd(odd), .dout(dout), .line_cnt(line_cnt), .busy(busy),
        .frame_done(frame_done),
`ifdef FRAME_STATS_EN
        .frame_cnt(frame_cnt), .drop_cnt(drop_cnt),
`endif
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0, fd_cnt = 0, shoot_cnt = 0;
    logic [8:0] expq[$];
    logic [8:0] mon_e;

    always @(negedge clk) begin
        if (res_n) begin
            if (frame_done) fd_cnt++;
            if (shoot) begin
                shoot_cnt++;
                tests++;
                if (expq.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_shoot: got odd=%0b dout=%02h, expected no shoot", odd, dout);
                end else begin
                    mon_e = expq.pop_front();
                    if ({odd, dout} !== mon_e) begin
                        fails++;
                        $display("FAIL shoot_data: got odd=%0b dout=%02h, expected odd=%0b dout=%02h",
                                 odd, dout, mon_e[8], mon_e[7:0]);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit exp, input bit exp_odd);
        if (exp) expq.push_back({exp_odd, b});
        din = b;
        wclk(2);
        pclk = 1'b1;
        wclk(3);
        pclk = 1'b0;
        wclk(3);
    endtask

    // one href-framed line; drop_px selects the pixel during which q_gful is held high
    task automatic line(input int ln, input int nb, input bit inwin, input int drop_px);
        href = 1'b1;
        wclk(6);
        for (int i = 0; i < nb; i++) begin
            if ((i % 2 == 0) && (i / 2 == drop_px)) q_gful = 1'b1;
            send_byte(8'((ln << 4) | (i + 1)), inwin && (i / 2 != drop_px), (i % 2 == 0));
            if ((i % 2 == 1) && (i / 2 == drop_px)) q_gful = 1'b0;
        end
        href = 1'b0;
        wclk(6);
    endtask

    task automatic frame_start();
        vsync = 1'b1;
        wclk(6);
        vsync = 1'b0;
        wclk(6);
    endtask

    task automatic frame_stop();
        vsync = 1'b1;
        wclk(6);
    endtask

    task automatic frame(input int nl, input int nb, input int lo, input int hi,
                         input int drop_ln, input int drop_px, input bit en);
        frame_start();
        for (int ln = 0; ln < nl; ln++)
            line(ln, nb, en && ln >= lo && ln <= hi, (ln == drop_ln) ? drop_px : -1);
        frame_stop();
    endtask

    initial begin
        wclk(3);
        chk("rst_shoot", 32'(shoot), 0);
        chk("rst_odd", 32'(odd), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_line_cnt", 32'(line_cnt), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_frame_done", 32'(frame_done), 0);
        res_n = 1'b1;
        cfg_enable = 1'b1;
        wclk(2);
        chk("enable_busy", 32'(busy), 1);

        // window 2..3, six lines of four bytes
        ls = 10'd2; le = 10'd3;
        frame(6, 4, 2, 3, -1, -1, 1'b1);
        chk("t1_line_cnt", 32'(line_cnt), 6);
        chk("t1_frames", 32'(fd_cnt), 1);
        chk("t1_shoots", 32'(shoot_cnt), 8);
        chk("t1_overflow", 32'(overflow), 0);
        chk("t1_busy", 32'(busy), 1);

        // green queue full across pixel 1 of line 2
        frame(6, 4, 2, 3, 2, 1, 1'b1);
        chk("t2_overflow", 32'(overflow), 1);
        chk("t2_shoots", 32'(shoot_cnt), 14);
        chk("t2_frames", 32'(fd_cnt), 2);
`ifdef FRAME_STATS_EN
        chk("t2_drop_cnt", 32'(drop_cnt), 1);
        chk("t2_frame_cnt", 32'(frame_cnt), 2);
`endif

        // enable dropped mid-frame: frame still finishes
        ls = 10'd0; le = 10'd0;
        frame_start();
        line(0, 4, 1'b1, -1);
        cfg_enable = 1'b0;
        line(1, 4, 1'b0, -1);
        frame_stop();
        chk("t4_frames", 32'(fd_cnt), 3);
        chk("t4_busy", 32'(busy), 0);
        chk("t4_line_cnt", 32'(line_cnt), 2);
        chk("t4_shoots", 32'(shoot_cnt), 18);
        chk("t4_overflow_held", 32'(overflow), 1);
        frame(2, 4, 0, 0, -1, -1, 1'b0);
        chk("t4_idle_frames", 32'(fd_cnt), 3);
        chk("t4_idle_shoots", 32'(shoot_cnt), 18);
        cfg_enable = 1'b1;
        wclk(2);
        chk("t4_overflow_clr", 32'(overflow), 0);
        chk("t4_rebusy", 32'(busy), 1);

        // half pixel at href fall
        ls = 10'd0; le = 10'd1;
        frame_start();
        line(0, 3, 1'b1, -1);
        line(1, 4, 1'b1, -1);
        frame_stop();
        chk("t3_overflow", 32'(overflow), 1);
        chk("t3_shoots", 32'(shoot_cnt), 25);
        chk("t3_frames", 32'(fd_cnt), 4);

        // empty window (start > end)
        ls = 10'd5; le = 10'd2;
        frame(6, 4, 5, 2, -1, -1, 1'b1);
        chk("t6_shoots", 32'(shoot_cnt), 25);
        chk("t6_frames", 32'(fd_cnt), 5);
        chk("t6_line_cnt", 32'(line_cnt), 6);

        // reset in the middle of a captured line
        ls = 10'd0; le = 10'd0;
        frame_start();
        href = 1'b1;
        wclk(6);
        send_byte(8'hC1, 1'b1, 1'b1);
        res_n = 1'b0;
        #1;
        chk("t5_shoot", 32'(shoot), 0);
        chk("t5_odd", 32'(odd), 1);
        chk("t5_line_cnt", 32'(line_cnt), 0);
        chk("t5_overflow", 32'(overflow), 0);
        chk("t5_busy", 32'(busy), 0);
        wclk(2);
        res_n = 1'b1;
        send_byte(8'hC2, 1'b0, 1'b0);
        href = 1'b0;
        wclk(6);
        chk("t5_busy_after", 32'(busy), 1);
        frame(1, 2, 0, 0, -1, -1, 1'b1);
        chk("t5_shoots", 32'(shoot_cnt), 28);
        chk("t5_frames", 32'(fd_cnt), 6);
        chk("t5_line_cnt_end", 32'(line_cnt), 1);
`ifdef FRAME_STATS_EN
        chk("t5_frame_cnt", 32'(frame_cnt), 1);
        chk("t5_drop_cnt", 32'(drop_cnt), 0);
`endif
        chk("queue_empty", 32'(expq.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
